// File: rtl/exception_ctrl.sv
// Purpose : exception responder - records cause/EPC in CP0 registers, flushes, vectors to the handler, services ERET; double fault halts.
// Latency : fault sampled at edge N -> FLUSH in cycle N+1, redirect to handler in N+2; ERET at edge M -> redirect to EPC in M+1.
// Backpressure: none accepted; drives stall/flush into the pipeline, and holds stall/flush/halted permanently after a double fault until reset.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   ex_valid, ex_pc            EX-stage instruction valid and its PC
//   pc_exception, alu_status   fault indications (alu_status bits 2/3/6 used)
//   eret                       EX instruction is ERET
//   cp0_rd_sel, cp0_rd_data    combinational CP0 read port
//   cp0_we, cp0_wr_sel, cp0_wr_data   CP0 write port (STATUS and EPC only)
//   flush, stall, pc_redirect, pc_target, in_handler, halted   registered pipeline controls
module exception_ctrl #(
    parameter logic [31:0] HANDLER_VEC = 32'h0000_0080
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_valid,
    input  logic [31:0] ex_pc,
    input  logic        pc_exception,
    input  logic [7:0]  alu_status,
    input  logic        eret,
    input  logic [1:0]  cp0_rd_sel,
    output logic [31:0] cp0_rd_data,
    input  logic        cp0_we,
    input  logic [1:0]  cp0_wr_sel,
    input  logic [31:0] cp0_wr_data,
    output logic        flush,
    output logic        stall,
    output logic        pc_redirect,
    output logic [31:0] pc_target,
    output logic        in_handler,
    output logic        halted
);

    typedef enum logic [2:0] {
        ST_RUN    = 3'd0,
        ST_FLUSH  = 3'd1,
        ST_VECTOR = 3'd2,
        ST_RETURN = 3'd3,
        ST_HALT   = 3'd4
    } state_t;

    localparam logic [1:0] SEL_STATUS = 2'd0;
    localparam logic [1:0] SEL_CAUSE  = 2'd1;
    localparam logic [1:0] SEL_EPC    = 2'd2;
    localparam logic [1:0] SEL_COUNT  = 2'd3;

    state_t      state;
    logic        exl;
    logic [3:0]  cause;
    logic [31:0] epc;
    logic [15:0] exc_count;

    logic        fault;
    logic [3:0]  fault_code;
    logic        wr_status;
    logic        wr_epc;
    logic [31:0] epc_fwd;

    assign fault = ex_valid & (pc_exception | alu_status[2] | alu_status[3] | alu_status[6]);

    always_comb begin
        fault_code = 4'd0;
        if (pc_exception)       fault_code = 4'd1;
        else if (alu_status[2]) fault_code = 4'd2;
        else if (alu_status[3]) fault_code = 4'd3;
        else if (alu_status[6]) fault_code = 4'd4;
    end

    // CP0 writes are dropped once halted.
    assign wr_status = cp0_we && (cp0_wr_sel == SEL_STATUS) && (state != ST_HALT);
    assign wr_epc    = cp0_we && (cp0_wr_sel == SEL_EPC)    && (state != ST_HALT);

    // An EPC write landing on the same edge as an ERET must still steer the return address.
    assign epc_fwd = wr_epc ? cp0_wr_data : epc;

    always_comb begin
        cp0_rd_data = 32'd0;
        case (cp0_rd_sel)
            SEL_STATUS: cp0_rd_data = {31'd0, exl};
            SEL_CAUSE:  cp0_rd_data = {28'd0, cause};
            SEL_EPC:    cp0_rd_data = epc;
            SEL_COUNT:  cp0_rd_data = {16'd0, exc_count};
            default:    cp0_rd_data = 32'd0;
        endcase
    end

    assign in_handler = exl;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_RUN;
            exl         <= 1'b0;
            cause       <= 4'd0;
            epc         <= 32'd0;
            exc_count   <= 16'd0;
            flush       <= 1'b0;
            stall       <= 1'b0;
            pc_redirect <= 1'b0;
            pc_target   <= 32'd0;
            halted      <= 1'b0;
        end else begin
            // Software writes first; capture / EXL updates below override them.
            if (wr_status) exl <= cp0_wr_data[0];
            if (wr_epc)    epc <= cp0_wr_data;

            // Outputs default to idle; each transition sets the next state's outputs.
            flush       <= 1'b0;
            stall       <= 1'b0;
            pc_redirect <= 1'b0;
            pc_target   <= 32'd0;
            halted      <= 1'b0;

            case (state)
                ST_RUN: begin
                    if (fault && !exl) begin
                        epc   <= ex_pc;
                        cause <= fault_code;
                        exl   <= 1'b1;
                        if (exc_count != 16'hFFFF) exc_count <= exc_count + 16'd1;
                        state <= ST_FLUSH;
                        flush <= 1'b1;
                        stall <= 1'b1;
                    end else if (fault) begin
                        state  <= ST_HALT;
                        flush  <= 1'b1;
                        stall  <= 1'b1;
                        halted <= 1'b1;
                    end else if (eret && ex_valid && exl) begin
                        exl         <= 1'b0;
                        state       <= ST_RETURN;
                        flush       <= 1'b1;
                        pc_redirect <= 1'b1;
                        pc_target   <= epc_fwd;
                    end
                end
                ST_FLUSH: begin
                    state       <= ST_VECTOR;
                    flush       <= 1'b1;
                    pc_redirect <= 1'b1;
                    pc_target   <= HANDLER_VEC;
                end
                ST_VECTOR: state <= ST_RUN;
                ST_RETURN: state <= ST_RUN;
                ST_HALT: begin
                    state  <= ST_HALT;
                    flush  <= 1'b1;
                    stall  <= 1'b1;
                    halted <= 1'b1;
                end
                default: state <= ST_RUN;
            endcase
        end
    end

endmodule

// File: doc/exception_ctrl.md
# exception_ctrl

Sequential exception responder for the MIPS pipeline. Consumes the per-instruction fault indications produced in EX, where memory-side suppression of the faulting instruction is already applied combinationally. It then records cause and EPC in a small CP0-style register file, flushes the pipeline, redirects fetch to the handler vector, and services ERET back to the saved PC. A second fault inside the handler halts the core until reset.

## Interface
- `HANDLER_VEC`, default 32'h0000_0080: fetch address of the exception handler.
- `clk`  in  1: single clock, rising-edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `ex_valid`  in  1: EX holds a real (non-bubble) instruction.
- `ex_pc`  in  32: PC of the instruction in EX.
- `pc_exception`  in  1: fetch fault on the EX instruction.
- `alu_status`  in  8: bit 2 misaligned address, bit 3 divide-by-zero, bit 6 overflow; other bits ignored.
- `eret`  in  1: EX instruction is ERET.
- `cp0_rd_sel`  in  2: read select; 0 STATUS, 1 CAUSE, 2 EPC, 3 EXC_COUNT.
- `cp0_rd_data`  out  32: combinational read of the selected register.
- `cp0_we`  in  1: CP0 write strobe.
- `cp0_wr_sel`  in  2: write select; only STATUS (0) and EPC (2) are writable.
- `cp0_wr_data`  in  32: write data.
- `flush`  out  1: squash IF/ID/EX contents this cycle.
- `stall`  out  1: hold PC and pipeline registers.
- `pc_redirect`  out  1: load `pc_target` into PC this cycle.
- `pc_target`  out  32: redirect address.
- `in_handler`  out  1: STATUS.EXL.
- `halted`  out  1: double-fault halt.

## Operation
- Fault detected = `ex_valid` & (`pc_exception` | `alu_status[2]` | `alu_status[3]` | `alu_status[6]`). Sampled only in state RUN.
- Cause priority, with the 4-bit code: `pc_exception` 1 > misaligned 2 > div-by-zero 3 > overflow 4.
- Registers:
  - STATUS: bit 0 = EXL; other bits read 0.
  - CAUSE: {28'b0, code}.
  - EPC: 32 bits.
  - EXC_COUNT: 16-bit saturating at 16'hFFFF, zero-extended on read.
- States are RUN, FLUSH, VECTOR, RETURN, HALT.
- RUN, fault with EXL=0:
  - Capture EPC=`ex_pc` and CAUSE=code; set EXL; increment EXC_COUNT.
  - Go to FLUSH.
- RUN, fault with EXL=1: double fault. CAUSE, EPC and EXC_COUNT are unchanged. Go to HALT.
- FLUSH: `flush`=1, `stall`=1; go to VECTOR.
- VECTOR: `flush`=1, `pc_redirect`=1, `pc_target`=`HANDLER_VEC`; go to RUN.
- RUN, `eret` & `ex_valid` & EXL=1, no fault: clear EXL; go to RETURN.
- RETURN: `flush`=1, `pc_redirect`=1, `pc_target`=EPC; go to RUN.
- `eret` with EXL=0: ignored, no state change.
- Fault and `eret` in the same cycle: the fault is taken and `eret` is ignored.
- HALT: `stall`=1, `flush`=1, `halted`=1 permanently; all inputs ignored; exit only by reset.
- CP0 writes:
  - Accepted in any state except HALT.
  - A write to STATUS sets EXL = `cp0_wr_data[0]`.
  - If a capture or EXL update occurs in the same cycle, the capture/EXL update wins over the write.
- Outputs not listed for a state are 0; `pc_target` is 0 when `pc_redirect`=0.

## Timing
- Reset (asynchronous, `rst_n`=0): state RUN; STATUS, CAUSE, EPC, EXC_COUNT = 0; all outputs 0.
- Reset mid-sequence (FLUSH/VECTOR/RETURN/HALT) returns immediately to the reset state; no redirect is issued.
- Fault sampled at edge N leads to:
  - FLUSH during cycle N+1.
  - VECTOR (redirect) during cycle N+2.
  - RUN from N+3.
  - Total 2 cycles of `flush`.
- ERET sampled at edge M leads to:
  - RETURN during cycle M+1.
  - RUN from M+2.
- `in_handler` reflects EXL the cycle after the capturing/clearing edge.
- CP0 register updates are visible on `cp0_rd_data` the cycle after the write.
- Faults presented during FLUSH, VECTOR or RETURN are ignored; those instructions are being squashed.
- EXC_COUNT at 16'hFFFF stays at 16'hFFFF.

## Test plan
- Overflow fault:
  - Stimulus: `ex_valid`=1, `ex_pc`=32'h0000_0040, `alu_status`=8'h40.
  - Response: cycle +1 `flush`=1 and `stall`=1; cycle +2 `pc_redirect`=1 with `pc_target`=32'h80; afterwards EPC=32'h40, CAUSE=4, EXL=1, EXC_COUNT=1.
- Priority:
  - Stimulus: `pc_exception`=1 and `alu_status`=8'h4C together.
  - Response: CAUSE=1.
- ERET:
  - Stimulus: after the handler entry above, assert `eret`.
  - Response: next cycle `pc_redirect`=1, `pc_target`=32'h40, `flush`=1; EXL=0 the following cycle.
  - Also: `eret` with EXL=0 produces no redirect.
- Double fault:
  - Stimulus: with EXL=1, `alu_status`=8'h08.
  - Response: `halted`, `stall` and `flush` stay 1 for 10+ cycles; CAUSE and EPC unchanged.
  - Then: assert `rst_n`=0 → all outputs and registers are 0 asynchronously.
- Bubble and in-flight faults:
  - Stimulus: `ex_valid`=0 with `alu_status`=8'h40.
  - Response: no action.
  - Stimulus: a fault during FLUSH.
  - Response: ignored, EXC_COUNT unchanged.
- CP0 access and collision:
  - Stimulus: write EPC=32'h100 via `cp0_we`, then ERET with EXL=1.
  - Response: `pc_target`=32'h100.
  - Stimulus: CP0 STATUS write of 0 coinciding with a fault capture.
  - Response: EXL=1.
